// File: rtl/pll_iobuf_arbiter_if.sv
// Requester-side handshake bundle for pll_iobuf_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface pll_iobuf_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_wr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/pll_iobuf_arbiter.sv
// Round-robin arbiter sharing one bidirectional pll_iobuf pad between N_REQ requesters.
// Define IOBUF_ARB_PARITY_EN to append an even-parity bit to every serialized word.
module pll_iobuf_arbiter #(
  parameter int unsigned  N_REQ     = 2,
  parameter int unsigned  DATA_W    = 8,
  parameter int unsigned  TA_CYCLES = 2,
  localparam int unsigned IdW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pll_iobuf_arbiter_if.slave bus,
  output logic               pad_i,
  output logic               pad_oe,
  input  logic               pad_o,
  output logic               busy,
  output logic [IdW-1:0]     grant_id
);

`ifdef IOBUF_ARB_PARITY_EN
  localparam int unsigned ParW = 1;
`else
  localparam int unsigned ParW = 0;
`endif
  localparam int unsigned W      = DATA_W + ParW;
  localparam int unsigned CntMax = (W > TA_CYCLES) ? W : TA_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StShift, StTurn, StDone} state_e;

  state_e            state_q;
  logic [IdW-1:0]    rr_q, owner_q, pick_id, rr_next;
  logic              pick_found, pick_wr;
  logic              wr_q;
  logic [W-1:0]      sreg_q, tx_word;
  logic [CntW-1:0]   cnt_q;
  logic              pad_i_q, pad_oe_q, resp_err_q, rx_err;
  logic [N_REQ-1:0]  resp_valid_q, owner_onehot, ready;
  logic [DATA_W-1:0] resp_rdata_q, wdata_sel, rx_data;

  // First valid requester at or above the rr pointer, wrapping around.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      j = int'(rr_q) + i;
      if (j >= int'(N_REQ)) j = j - int'(N_REQ);
      if (!pick_found && bus.req_valid[j]) begin
        pick_found = 1'b1;
        pick_id    = IdW'(j);
      end
    end
  end

  assign rr_next   = (pick_id == IdW'(N_REQ - 1)) ? '0 : pick_id + 1'b1;
  assign pick_wr   = bus.req_wr[pick_id];
  assign wdata_sel = bus.req_wdata[int'(pick_id) * int'(DATA_W) +: DATA_W];
  assign rx_data   = sreg_q[W-1 -: DATA_W];

`ifdef IOBUF_ARB_PARITY_EN
  assign tx_word = {wdata_sel, ^wdata_sel};
  assign rx_err  = ^sreg_q;
`else
  assign tx_word = wdata_sel;
  assign rx_err  = 1'b0;
`endif

  always_comb begin
    ready        = '0;
    owner_onehot = '0;
    owner_onehot[owner_q] = 1'b1;
    if (state_q == StIdle && pick_found) ready[pick_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      owner_q      <= '0;
      wr_q         <= 1'b0;
      sreg_q       <= '0;
      cnt_q        <= '0;
      pad_i_q      <= 1'b0;
      pad_oe_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            owner_q  <= pick_id;
            rr_q     <= rr_next;
            wr_q     <= pick_wr;
            cnt_q    <= CntW'(W - 1);
            pad_oe_q <= pick_wr;
            pad_i_q  <= pick_wr & tx_word[W-1];
            sreg_q   <= pick_wr ? (tx_word << 1) : '0;
            state_q  <= StShift;
          end
        end
        StShift: begin
          // Writes shift the word out; reads shift the pad in, MSB first.
          sreg_q <= {sreg_q[W-2:0], wr_q ? 1'b0 : pad_o};
          if (cnt_q == '0) begin
            pad_oe_q <= 1'b0;
            pad_i_q  <= 1'b0;
            cnt_q    <= CntW'(TA_CYCLES - 1);
            state_q  <= StTurn;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (wr_q) pad_i_q <= sreg_q[W-1];
          end
        end
        StTurn: begin
          if (cnt_q == '0) begin
            resp_valid_q <= owner_onehot;
            resp_rdata_q <= wr_q ? '0 : rx_data;
            resp_err_q   <= ~wr_q & rx_err;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign pad_i          = pad_i_q;
  assign pad_oe         = pad_oe_q;
  assign busy           = (state_q != StIdle);
  assign grant_id       = owner_q;

endmodule
